// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter for the CCI-P c0 read request channel with response routing by mdata tag.
// Optional macro C0_ARB_PERF_CNT_EN builds a stall counter on perf_stall_cnt; otherwise it reads 0.
module ccip_c0_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int HDR_W   = 74,
    parameter int MAX_OUT = 64
) (
    input  logic                     afu_clk,
    input  logic                     afu_rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*HDR_W-1:0] req_hdr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     tx_valid,
    output logic [HDR_W-1:0]         tx_hdr,
    input  logic                     tx_almfull,
    input  logic                     rsp_valid,
    input  logic [15:0]              rsp_mdata,
    output logic [NUM_REQ-1:0]       rsp_sel,
    output logic                     idle,
    output logic [1:0]               err,
    output logic [31:0]              perf_stall_cnt
);

    localparam int              CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0]   r_cnt [NUM_REQ];
    logic [ID_W-1:0]    r_ptr;
    logic               r_tx_valid;
    logic [HDR_W-1:0]   r_tx_hdr;
    logic [NUM_REQ-1:0] r_rsp_sel;
    logic [1:0]         r_err;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_cnt_zero;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [HDR_W-1:0]   w_sel_hdr;
    logic [ID_W-1:0]    w_rsp_id;
    logic               w_rsp_in_range;
    logic [NUM_REQ-1:0] w_rsp_hit;
    logic [15-ID_W:0]   w_unused_mdata;

    function automatic int wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        return (s >= NUM_REQ) ? (s - NUM_REQ) : s;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cnt_zero[i] = (r_cnt[i] == '0);
            w_elig[i]     = req_valid[i] && (r_cnt[i] < CNT_MAX);
        end
    end

    // Round-robin search starting at r_ptr; almost-full suppresses every grant.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        if (!tx_almfull) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!w_found && w_elig[i] && (wrap_idx(int'(r_ptr), k) == i)) begin
                        w_found   = 1'b1;
                        w_gnt_idx = ID_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        w_sel_hdr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = w_found && (w_gnt_idx == ID_W'(i));
            if (w_grant[i]) begin
                w_sel_hdr = req_hdr[i*HDR_W +: HDR_W];
            end
        end
    end

    assign req_ready      = w_grant;
    assign w_rsp_id       = rsp_mdata[15 -: ID_W];
    assign w_rsp_in_range = (int'(w_rsp_id) < NUM_REQ);
    assign w_unused_mdata = rsp_mdata[15-ID_W:0];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_hit[i] = rsp_valid && w_rsp_in_range && (w_rsp_id == ID_W'(i));
        end
    end

    always_ff @(posedge afu_clk or negedge afu_rst_n) begin
        if (!afu_rst_n) begin
            r_tx_valid <= 1'b0;
            r_tx_hdr   <= '0;
            r_ptr      <= '0;
        end else begin
            r_tx_valid <= w_found;
            if (w_found) begin
                r_tx_hdr <= {w_sel_hdr[HDR_W-1:16], w_gnt_idx, w_sel_hdr[15-ID_W:0]};
                if (int'(w_gnt_idx) == NUM_REQ - 1) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gnt_idx + ID_W'(1);
                end
            end
        end
    end

    // A grant and a response for the same requester cancel out; underflow saturates at 0.
    always_ff @(posedge afu_clk or negedge afu_rst_n) begin
        if (!afu_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
            r_rsp_sel <= '0;
            r_err     <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && !w_rsp_hit[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (!w_grant[i] && w_rsp_hit[i] && !w_cnt_zero[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
            r_rsp_sel <= w_rsp_hit;
            r_err[0]  <= r_err[0] | (rsp_valid & ~w_rsp_in_range);
            r_err[1]  <= r_err[1] | (|(w_rsp_hit & w_cnt_zero));
        end
    end

`ifdef C0_ARB_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge afu_clk or negedge afu_rst_n) begin
        if (!afu_rst_n) begin
            r_stall_cnt <= '0;
        end else if ((|req_valid) && !w_found) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

    assign tx_valid = r_tx_valid;
    assign tx_hdr   = r_tx_hdr;
    assign rsp_sel  = r_rsp_sel;
    assign err      = r_err;
    assign idle     = ~r_tx_valid & (&w_cnt_zero);

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Bench for ccip_c0_rd_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_ccip_c0_rd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int HDR_W   = 74;
    localparam int MAX_OUT = 2;

    logic                     afu_clk = 1'b0;
    logic                     afu_rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*HDR_W-1:0] req_hdr = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     tx_valid;
    logic [HDR_W-1:0]         tx_hdr;
    logic                     tx_almfull = 1'b0;
    logic                     rsp_valid = 1'b0;
    logic [15:0]              rsp_mdata = '0;
    logic [NUM_REQ-1:0]       rsp_sel;
    logic                     idle;
    logic [1:0]               err;
    logic [31:0]              perf_stall_cnt;

    ccip_c0_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .HDR_W(HDR_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .afu_clk(afu_clk), .afu_rst_n(afu_rst_n),
        .req_valid(req_valid), .req_hdr(req_hdr), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_hdr(tx_hdr), .tx_almfull(tx_almfull),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_sel(rsp_sel),
        .idle(idle), .err(err), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 afu_clk = ~afu_clk;

    int total = 0;
    int bad = 0;

    // Reference state, derived from the arbitration rules rather than the RTL structure.
    int               m_cnt [NUM_REQ];
    int               m_ptr;
    logic             m_tx_valid;
    logic [HDR_W-1:0] m_tx_hdr;
    logic [NUM_REQ-1:0] m_rsp_sel;
    logic [1:0]       m_err;
    logic [31:0]      m_stall;

    task automatic m_reset();
        for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
        m_ptr = 0; m_tx_valid = 1'b0; m_tx_hdr = '0;
        m_rsp_sel = '0; m_err = '0; m_stall = '0;
    endtask

    function automatic int m_grant();
        int i;
        if (tx_almfull) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i] && m_cnt[i] < MAX_OUT) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int g);
        logic [NUM_REQ-1:0] r;
        for (int i = 0; i < NUM_REQ; i++) r[i] = (i == g);
        return r;
    endfunction

    function automatic logic m_idle();
        int s;
        s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += m_cnt[i];
        return (s == 0) && !m_tx_valid;
    endfunction

    function automatic logic [31:0] m_perf();
`ifdef C0_ARB_PERF_CNT_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [HDR_W-1:0] rand_hdr();
        return HDR_W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic set_hdr(input int i, input logic [HDR_W-1:0] h);
        req_hdr[i*HDR_W +: HDR_W] = h;
    endtask

    // One clock edge for both the DUT and the model; returns at edge+1 with g = granted index or -1.
    task automatic tick(output int g);
        logic [HDR_W-1:0] h;
        int id;
        g = m_grant();
        @(posedge afu_clk);
        id = int'(rsp_mdata[15 -: ID_W]);
        if (g >= 0) begin
            h = req_hdr[g*HDR_W +: HDR_W];
            h[15 -: ID_W] = ID_W'(g);
            m_tx_valid = 1'b1; m_tx_hdr = h; m_ptr = (g + 1) % NUM_REQ;
        end else begin
            m_tx_valid = 1'b0;
        end
        if ((|req_valid) && g < 0) m_stall = m_stall + 32'd1;
        m_rsp_sel = '0;
        if (rsp_valid && id >= NUM_REQ) m_err[0] = 1'b1;
        if (rsp_valid && id < NUM_REQ) begin
            m_rsp_sel = onehot(id);
            if (m_cnt[id] == 0) m_err[1] = 1'b1;
        end
        if (rsp_valid && id < NUM_REQ && id == g) begin
            // grant and response on the same requester leave the count as is
        end else begin
            if (g >= 0) m_cnt[g]++;
            if (rsp_valid && id < NUM_REQ && m_cnt[id] > 0) m_cnt[id]--;
        end
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; tx_almfull = 1'b0; rsp_valid = 1'b0; rsp_mdata = '0;
        #1 afu_rst_n = 1'b0;
        m_reset();
        @(negedge afu_clk);
        afu_rst_n = 1'b1;
        @(posedge afu_clk);
        #1;
    endtask

    task automatic test_reset();
        afu_rst_n = 1'b0;
        m_reset();
        #2;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_hdr !== '0) begin bad++; $display("FAIL reset_tx_hdr got=%h want=0", tx_hdr); end
        total++; if (rsp_sel !== '0) begin bad++; $display("FAIL reset_rsp_sel got=%b want=0", rsp_sel); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", err); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
        total++; if (perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d want=0", perf_stall_cnt); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b want=0", req_ready); end
        @(negedge afu_clk);
        afu_rst_n = 1'b1;
        @(posedge afu_clk);
        #1;
    endtask

    task automatic test_single();
        logic [HDR_W-1:0] h;
        int g;
        h = rand_hdr(); h[15:0] = 16'h0123;
        set_hdr(2, h); req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        tick(g);
        req_valid = '0;
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL single_tx_valid got=%b want=1", tx_valid); end
        total++; if (tx_hdr[15:0] !== 16'h8123) begin bad++; $display("FAIL single_mdata got=%h want=8123", tx_hdr[15:0]); end
        total++; if (tx_hdr !== m_tx_hdr) begin bad++; $display("FAIL single_hdr got=%h want=%h", tx_hdr, m_tx_hdr); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", idle); end
        tick(g);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL single_tx_drop got=%b want=0", tx_valid); end
        total++; if (tx_hdr !== m_tx_hdr) begin bad++; $display("FAIL single_hdr_hold got=%h want=%h", tx_hdr, m_tx_hdr); end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_hdr(i, rand_hdr());
        req_valid = '1;
        for (int n = 0; n < 8; n++) begin
            #1;
            total++;
            if (req_ready !== onehot(n % NUM_REQ)) begin
                bad++; $display("FAIL rr_order n=%0d got=%b want=%b", n, req_ready, onehot(n % NUM_REQ));
            end
            tick(g);
            if (g >= 0) set_hdr(g, rand_hdr());
            total++;
            if (tx_valid !== 1'b1 || tx_hdr !== m_tx_hdr) begin
                bad++; $display("FAIL rr_tx n=%0d got=%b/%h want=1/%h", n, tx_valid, tx_hdr, m_tx_hdr);
            end
        end
        #1;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL rr_all_at_limit got=%b want=0000", req_ready); end
    endtask

    task automatic test_almfull();
        int g;
        do_reset();
        set_hdr(0, rand_hdr()); req_valid = 4'b0001;
        tick(g);
        req_valid = '0;
        set_hdr(0, rand_hdr()); set_hdr(2, rand_hdr());
        req_valid = 4'b0101; tx_almfull = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            total++; if (req_ready !== '0) begin bad++; $display("FAIL almfull_ready n=%0d got=%b want=0", n, req_ready); end
            tick(g);
            total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL almfull_tx n=%0d got=%b want=0", n, tx_valid); end
        end
        total++; if (perf_stall_cnt !== m_perf()) begin bad++; $display("FAIL almfull_perf got=%0d want=%0d", perf_stall_cnt, m_perf()); end
`ifdef C0_ARB_PERF_CNT_EN
        total++; if (perf_stall_cnt !== 32'd5) begin bad++; $display("FAIL almfull_perf5 got=%0d want=5", perf_stall_cnt); end
`endif
        tx_almfull = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL almfull_resume got=%b want=0100", req_ready); end
        tick(g);
        if (g >= 0) req_valid[g] = 1'b0;
        total++; if (tx_valid !== 1'b1 || tx_hdr[15:14] !== 2'd2) begin
            bad++; $display("FAIL almfull_resume_tx got=%b/%0d want=1/2", tx_valid, tx_hdr[15:14]);
        end
        req_valid = '0;
        tick(g);
    endtask

    task automatic test_limit();
        int g;
        do_reset();
        req_valid = 4'b0010;
        for (int n = 0; n < 2; n++) begin
            set_hdr(1, rand_hdr());
            tick(g);
        end
        set_hdr(3, rand_hdr()); req_valid = 4'b1010;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL limit_other got=%b want=1000", req_ready); end
        tick(g);
        req_valid = 4'b0010;
        rsp_valid = 1'b1; rsp_mdata = 16'h4000;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL limit_block got=%b want=0000", req_ready); end
        tick(g);
        rsp_valid = 1'b0;
        total++; if (rsp_sel !== 4'b0010) begin bad++; $display("FAIL limit_rsp_sel got=%b want=0010", rsp_sel); end
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL limit_regrant got=%b want=0010", req_ready); end
        tick(g);
        req_valid = '0;
    endtask

    task automatic test_same_cycle();
        int g;
        do_reset();
        set_hdr(0, rand_hdr()); req_valid = 4'b0001;
        tick(g);
        set_hdr(0, rand_hdr());
        rsp_valid = 1'b1; rsp_mdata = 16'h0000;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL same_grant got=%b want=0001", req_ready); end
        tick(g);
        rsp_valid = 1'b0;
        total++; if (rsp_sel !== 4'b0001) begin bad++; $display("FAIL same_rsp_sel got=%b want=0001", rsp_sel); end
        set_hdr(0, rand_hdr());
        tick(g);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL same_cnt_kept got=%b want=0000", req_ready); end
        req_valid = '0;
        tick(g);
    endtask

    task automatic test_error_reset();
        int g;
        do_reset();
        rsp_valid = 1'b1; rsp_mdata = 16'hC000;
        tick(g);
        rsp_valid = 1'b0;
        total++; if (rsp_sel !== 4'b1000) begin bad++; $display("FAIL err_rsp_sel got=%b want=1000", rsp_sel); end
        total++; if (err !== 2'b10) begin bad++; $display("FAIL err_flag got=%b want=10", err); end
        for (int i = 0; i < NUM_REQ; i++) set_hdr(i, rand_hdr());
        req_valid = '1;
        for (int n = 0; n < 3; n++) begin
            tick(g);
            if (g >= 0) set_hdr(g, rand_hdr());
        end
        afu_rst_n = 1'b0;
        m_reset();
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_hdr !== '0) begin bad++; $display("FAIL rst_mid_tx_hdr got=%h want=0", tx_hdr); end
        total++; if (rsp_sel !== '0 || err !== 2'b00) begin bad++; $display("FAIL rst_mid_rsp_err got=%b/%b want=0/00", rsp_sel, err); end
        total++; if (idle !== 1'b1 || perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid_idle_perf got=%b/%0d want=1/0", idle, perf_stall_cnt); end
        total++; if (req_ready !== onehot(m_grant())) begin bad++; $display("FAIL rst_mid_ready got=%b want=%b", req_ready, onehot(m_grant())); end
        req_valid = '0;
        @(negedge afu_clk);
        afu_rst_n = 1'b1;
        @(posedge afu_clk);
        #1;
        rsp_valid = 1'b1; rsp_mdata = 16'h0000;
        tick(g);
        rsp_valid = 1'b0;
        total++; if (rsp_sel !== 4'b0001 || err !== 2'b10) begin bad++; $display("FAIL rst_stale_rsp got=%b/%b want=0001/10", rsp_sel, err); end
    endtask

    task automatic test_random();
        int g;
        int id;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_hdr(i, rand_hdr());
                    req_valid[i] = 1'b1;
                end
            end
            tx_almfull = ($urandom_range(0, 3) == 0);
            rsp_valid = 1'b0;
            id = int'($urandom_range(0, NUM_REQ - 1));
            if ($urandom_range(0, 1) == 1 && m_cnt[id] > 0) begin
                rsp_valid = 1'b1;
                rsp_mdata = {ID_W'(id), (16 - ID_W)'($urandom)};
            end
            #1;
            total++; if (req_ready !== onehot(m_grant())) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, req_ready, onehot(m_grant())); end
            tick(g);
            if (g >= 0) req_valid[g] = 1'b0;
            rsp_valid = 1'b0;
            total++; if (tx_valid !== m_tx_valid || tx_hdr !== m_tx_hdr) begin
                bad++; $display("FAIL rnd_tx cyc=%0d got=%b/%h want=%b/%h", cyc, tx_valid, tx_hdr, m_tx_valid, m_tx_hdr);
            end
            total++; if (rsp_sel !== m_rsp_sel || err !== m_err) begin
                bad++; $display("FAIL rnd_rsp cyc=%0d got=%b/%b want=%b/%b", cyc, rsp_sel, err, m_rsp_sel, m_err);
            end
            total++; if (idle !== m_idle() || perf_stall_cnt !== m_perf()) begin
                bad++; $display("FAIL rnd_idle_perf cyc=%0d got=%b/%0d want=%b/%0d", cyc, idle, perf_stall_cnt, m_idle(), m_perf());
            end
        end
        req_valid = '0; tx_almfull = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog elapsed=%0t want=finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_almfull();
        test_limit();
        test_same_cycle();
        test_error_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
